// File: rtl/quant_mult_pipe_pkg.sv
// Shared sizing constants and per-beat mode type for the quantised multiplier pipeline.
package quant_mult_pipe_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned QUAN_SIZE  = 8;
  localparam int unsigned MULT_LANES = 4;

  typedef struct packed {
    logic rnd;
    logic sat;
  } mode_t;

endpackage

// File: rtl/quant_mult_pipe_if.sv
// Beat-level handshake bundle between operand fetch, the multiplier and the adder trees.
interface quant_mult_pipe_if
  import quant_mult_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_SIZE,
  parameter int unsigned LANES  = MULT_LANES
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_a;
  logic [LANES*DATA_W-1:0]   in_b;
  logic                      rnd_en;
  logic                      sat_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_p;
  logic [LANES-1:0]          ovf_lane;
  logic                      ovf_sticky;
  logic                      ovf_clr;

  modport master (
    output in_valid, in_a, in_b, rnd_en, sat_en, out_ready, ovf_clr,
    input  in_ready, out_valid, out_p, ovf_lane, ovf_sticky
  );

  modport slave (
    input  in_valid, in_a, in_b, rnd_en, sat_en, out_ready, ovf_clr,
    output in_ready, out_valid, out_p, ovf_lane, ovf_sticky
  );

endinterface

// File: rtl/quant_mult_pipe_mult_lane.sv
// One multiplier lane: S2 full-width product, S3 round / arithmetic shift / saturate-or-wrap.
module quant_mult_pipe_mult_lane #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              s2_valid,
  input  logic              rnd_en,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p,
  output logic              ovf
);

  localparam int unsigned PW = 2 * DATA_W + 1;

  logic signed [2*DATA_W-1:0] prod_q;
  logic signed [PW-1:0]       ext;
  logic signed [PW-1:0]       half;
  logic signed [PW-1:0]       rounded;
  logic signed [PW-1:0]       shifted;
  logic [PW-DATA_W:0]         hi;
  logic                       ovf_d;
  logic [DATA_W-1:0]          p_d;
  logic [DATA_W-1:0]          p_q;
  logic                       ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (en) begin
      prod_q <= $signed(a) * $signed(b);
    end
  end

  always_comb begin
    ext     = {prod_q[2*DATA_W-1], prod_q};
    half    = PW'(1) << (FRAC_W - 1);
    rounded = rnd_en ? ext + half : ext;
    shifted = rounded >>> FRAC_W;
    // Result fits only if every bit from the output sign bit upward agrees.
    hi      = shifted[PW-1:DATA_W-1];
    ovf_d   = !((&hi) || !(|hi));
    p_d     = shifted[DATA_W-1:0];
    if (ovf_d && sat_en) begin
      p_d = shifted[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      p_q   <= p_d;
      ovf_q <= s2_valid & ovf_d;
    end
  end

  assign p   = p_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/quant_mult_pipe.sv
// Multi-lane pipelined signed fixed-point multiplier with global-enable flow control
// and a sticky overflow flag.
module quant_mult_pipe
  import quant_mult_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_SIZE,
  parameter int unsigned FRAC_W = QUAN_SIZE,
  parameter int unsigned LANES  = MULT_LANES
) (
  input logic              clk,
  input logic              rst_n,
  quant_mult_pipe_if.slave bus
);

  logic                    en;
  logic                    v1_q;
  logic                    v2_q;
  logic                    v3_q;
  logic [LANES*DATA_W-1:0] a_q;
  logic [LANES*DATA_W-1:0] b_q;
  mode_t                   mode1_q;
  mode_t                   mode2_q;
  logic [LANES*DATA_W-1:0] p;
  logic [LANES-1:0]        ovf;
  logic                    sticky_set;
  logic                    sticky_q;
  logic                    sticky_d;

  // A full output register only blocks the pipe when downstream refuses it.
  assign en           = !v3_q || bus.out_ready;
  assign bus.in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode1_q <= '0;
      mode2_q <= '0;
    end else if (en) begin
      v1_q        <= bus.in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      a_q         <= bus.in_a;
      b_q         <= bus.in_b;
      mode1_q.rnd <= bus.rnd_en;
      mode1_q.sat <= bus.sat_en;
      mode2_q     <= mode1_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    quant_mult_pipe_mult_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .s2_valid (v2_q),
      .rnd_en   (mode2_q.rnd),
      .sat_en   (mode2_q.sat),
      .a        (a_q[i*DATA_W +: DATA_W]),
      .b        (b_q[i*DATA_W +: DATA_W]),
      .p        (p[i*DATA_W +: DATA_W]),
      .ovf      (ovf[i])
    );
  end

  assign sticky_set = v3_q && bus.out_ready && (|ovf);

  always_comb begin
    sticky_d = sticky_q;
    if (bus.ovf_clr) sticky_d = 1'b0;
    if (sticky_set)  sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.out_valid  = v3_q;
  assign bus.out_p      = p;
  assign bus.ovf_lane   = ovf;
  assign bus.ovf_sticky = sticky_q;

endmodule
